// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------------------------
// fifo_stream_reader
//   Downstream consumer of a synchronous FIFO. It turns the FIFO pop interface (fifo_rd_en, with
//   fifo_data registered one cycle later) into a valid/ready stream. A small output buffer
//   absorbs words that are already in flight, so no popped word is ever lost. With
//   BUF_DEPTH >= 3 it sustains one word per clock.
//
//   Optional feature: define FIFO_RD_STATS_EN to build the transfer counter. Without the macro
//   xfer_count is tied to 0 and the port list stays the same.
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   synchronous active-low reset
//   fifo_data   in   FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_empty  in   FIFO empty flag
//   fifo_rd_en  out  pop request to the FIFO
//   flush       in   drop all buffered and in-flight words
//   m_data      out  stream data (buffer head)
//   m_valid     out  buffer non-empty and not flushing
//   m_ready     in   sink accepts when m_valid && m_ready
//   occupancy   out  buffered word count (0..BUF_DEPTH)
//   xfer_count  out  completed transfers, wraps at 2^CNT_WIDTH (stats build only)
// ---------------------------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned BUF_DEPTH = 3,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic                 flush,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [3:0]           occupancy,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    localparam int unsigned     PtrW     = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(BUF_DEPTH - 1);
    localparam logic [3:0]      DepthOcc = 4'(BUF_DEPTH);

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e          r_state, w_state_d;
    logic [WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PtrW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
    logic [3:0]      r_occ, w_occ_d;
    logic            r_inflight;
    logic            r_drop, w_drop_d;
    logic            w_credit, w_capture, w_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    // Credit covers buffered words plus the one possibly in flight, so a capture always has room.
    assign w_credit   = (r_occ + {3'b000, r_inflight}) < DepthOcc;
    assign fifo_rd_en = reset_n && (r_state == StRun) && !flush && !fifo_empty && w_credit;

    assign m_valid    = (r_state == StRun) && !flush && (r_occ != 4'd0);
    assign w_pop      = m_valid && m_ready;
    // A flush edge also discards the word arriving in that cycle.
    assign w_capture  = (r_state == StRun) && !flush && r_inflight && !r_drop;

    assign m_data     = r_buf[r_rd_ptr];
    assign occupancy  = r_occ;

    always_comb begin
        w_state_d  = r_state;
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_occ_d    = r_occ;
        w_drop_d   = r_drop;
        unique case (r_state)
            StRun: begin
                if (flush) begin
                    w_state_d  = StDrain;
                    w_wr_ptr_d = '0;
                    w_rd_ptr_d = '0;
                    w_occ_d    = 4'd0;
                    w_drop_d   = r_inflight;
                end else begin
                    if (w_capture) w_wr_ptr_d = ptr_inc(r_wr_ptr);
                    if (w_pop)     w_rd_ptr_d = ptr_inc(r_rd_ptr);
                    w_occ_d = r_occ + {3'b000, w_capture} - {3'b000, w_pop};
                end
            end
            StDrain: begin
                w_state_d = StRun;
                w_drop_d  = 1'b0;
            end
            default: w_state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StRun;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= 4'd0;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state    <= w_state_d;
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_occ      <= w_occ_d;
            r_inflight <= fifo_rd_en;
            r_drop     <= w_drop_d;
            if (w_capture) begin
                r_buf[r_wr_ptr] <= fifo_data;
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_WIDTH-1:0] r_xfer_count;

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_xfer_count <= '0;
        end else if (w_pop) begin
            r_xfer_count <= r_xfer_count + 1'b1;
        end
    end

    assign xfer_count = r_xfer_count;
`else
    assign xfer_count = '0;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_capture && (r_occ == DepthOcc)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned BUF_DEPTH = 3;
    localparam int unsigned CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [WIDTH-1:0]     fifo_data;
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic                 flush;
    logic [WIDTH-1:0]     m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [3:0]           occupancy;
    logic [CNT_WIDTH-1:0] xfer_count;

    fifo_stream_reader #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .occupancy  (occupancy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Environment FIFO contents and the reference model of the reader.
    logic [WIDTH-1:0] fifoq[$];
    logic [WIDTH-1:0] exp_buf[$];
    logic             mdl_infl  = 1'b0;
    logic [WIDTH-1:0] mdl_word  = '0;
    logic             mdl_drain = 1'b0;
    int               mdl_xfer  = 0;

    // Values observed in the most recent step.
    logic             g_rd, g_valid, g_acc;
    logic [WIDTH-1:0] g_data;
    logic [3:0]       g_occ;

    logic [WIDTH-1:0] got[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_xfer(input int n);
`ifdef FIFO_RD_STATS_EN
        return 32'(n % (1 << CNT_WIDTH));
`else
        return 32'(n * 0);
`endif
    endfunction

    // One clock: drive, check outputs at negedge against the model, advance past posedge.
    task automatic step();
        logic e_rd, e_valid;
        fifo_empty = (fifoq.size() == 0);
        @(negedge clk);
        e_rd    = reset_n && !mdl_drain && !flush && !fifo_empty
                  && ((exp_buf.size() + (mdl_infl ? 1 : 0)) < int'(BUF_DEPTH));
        e_valid = !mdl_drain && !flush && (exp_buf.size() != 0);
        check_eq("fifo_rd_en", 32'(fifo_rd_en), 32'(e_rd));
        check_eq("m_valid", 32'(m_valid), 32'(e_valid));
        check_eq("occupancy", 32'(occupancy), 32'(exp_buf.size()));
        if (e_valid) check_eq("m_data", 32'(m_data), 32'(exp_buf[0]));
        check_eq("xfer_count", 32'(xfer_count), exp_xfer(mdl_xfer));
        g_rd    = fifo_rd_en;
        g_valid = m_valid;
        g_data  = m_data;
        g_occ   = occupancy;
        g_acc   = m_valid && m_ready;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            exp_buf.delete();
            mdl_drain = 1'b0;
            mdl_xfer  = 0;
        end else if (mdl_drain) begin
            mdl_drain = 1'b0;
        end else if (flush) begin
            exp_buf.delete();
            mdl_drain = 1'b1;
        end else begin
            if (e_valid && m_ready) begin
                void'(exp_buf.pop_front());
                mdl_xfer++;
            end
            if (mdl_infl) exp_buf.push_back(mdl_word);
        end
        mdl_infl = 1'b0;
        if (g_rd && fifoq.size() > 0) begin
            mdl_word  = fifoq.pop_front();
            fifo_data = mdl_word;
            mdl_infl  = 1'b1;
        end
    endtask

    task automatic drain_all();
        m_ready = 1'b1;
        flush   = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (fifoq.size() == 0 && exp_buf.size() == 0 && !mdl_infl) break;
            step();
        end
    endtask

    initial begin
        int first, last, gap, acc;
        reset_n    = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_data  = '0;
        fifo_empty = 1'b0;
        for (int i = 1; i <= 16; i++) fifoq.push_back(WIDTH'(i));
        repeat (2) @(posedge clk);
        #1;

        // Reset with data available: no pop, everything idle.
        step();
        check_eq("rst_rd_en", 32'(g_rd), 32'(0));
        check_eq("rst_m_valid", 32'(g_valid), 32'(0));
        check_eq("rst_occupancy", 32'(g_occ), 32'(0));
        check_eq("rst_m_data", 32'(g_data), 32'(0));
        check_eq("rst_xfer_count", 32'(xfer_count), 32'(0));

        // Streaming 16 words at full rate.
        reset_n = 1'b1;
        m_ready = 1'b1;
        first   = -1;
        last    = -1;
        got.delete();
        for (int c = 0; c < 24; c++) begin
            step();
            if (g_valid) begin
                if (first < 0) first = c;
                last = c;
                got.push_back(g_data);
            end
        end
        check_eq("stream_latency", 32'(first), 32'(2));
        check_eq("stream_span", 32'(last - first), 32'(15));
        check_eq("stream_len", 32'(got.size()), 32'(16));
        for (int i = 0; i < got.size(); i++) check_eq("stream_word", 32'(got[i]), 32'(i + 1));

        // Backpressure: buffer fills to its depth and holds the head word.
        for (int i = 1; i <= 5; i++) fifoq.push_back(WIDTH'(i));
        m_ready = 1'b0;
        repeat (8) step();
        check_eq("bp_occupancy", 32'(g_occ), 32'(BUF_DEPTH));
        check_eq("bp_rd_en", 32'(g_rd), 32'(0));
        check_eq("bp_m_data", 32'(g_data), 32'(1));
        m_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            step();
            if (g_valid) got.push_back(g_data);
        end
        check_eq("bp_len", 32'(got.size()), 32'(5));
        for (int i = 0; i < got.size(); i++) check_eq("bp_word", 32'(got[i]), 32'(i + 1));

        // Flush with a read in flight: that word is lost, the next one follows.
        drain_all();
        for (int i = 0; i < 3; i++) fifoq.push_back(WIDTH'(16'h0100 + i));
        step();
        check_eq("fl_rd_issued", 32'(g_rd), 32'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        gap   = 1;
        first = -1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (g_valid) begin
                first = int'(g_data);
                break;
            end
            gap++;
        end
        check_eq("fl_next_word", 32'(first), 32'(16'h0101));
        check_eq("fl_gap_ge2", 32'(gap >= 2), 32'(1));

        // Reset while two words are buffered.
        drain_all();
        for (int i = 0; i < 5; i++) fifoq.push_back(WIDTH'(16'h0200 + i));
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (exp_buf.size() == 2) break;
            step();
        end
        check_eq("mr_reached_occ2", 32'(exp_buf.size()), 32'(2));
        reset_n = 1'b0;
        step();
        check_eq("mr_occ_at_reset", 32'(g_occ), 32'(2));
        check_eq("mr_rd_in_reset", 32'(g_rd), 32'(0));
        reset_n = 1'b1;
        step();
        check_eq("mr_occ_after", 32'(g_occ), 32'(0));
        check_eq("mr_valid_after", 32'(g_valid), 32'(0));
        drain_all();

        // Transfer counter wraps.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 300; i++) fifoq.push_back(WIDTH'($urandom));
        m_ready = 1'b1;
        acc     = 0;
        for (int c = 0; c < 400 && acc < 300; c++) begin
            step();
            if (g_acc) acc++;
        end
        check_eq("stats_xfers", 32'(acc), 32'(300));
`ifdef FIFO_RD_STATS_EN
        check_eq("stats_wrap", 32'(xfer_count), 32'(44));
`else
        check_eq("stats_tied", 32'(xfer_count), 32'(0));
`endif

        // Random traffic, flushes and resets against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) != 0 && fifoq.size() < 20) fifoq.push_back(WIDTH'($urandom));
            m_ready = ($urandom_range(0, 99) < 60);
            flush   = ($urandom_range(0, 99) < 4);
            reset_n = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1'b1;
        flush   = 1'b0;
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
